// File: rtl/branch_redirect_ctrl.sv
// Branch redirect sequencer: after an EXE-stage branch resolves taken, latches the
// target, issues a one-cycle PC select plus pipeline flushes, and tracks branch stats.
module branch_redirect_ctrl #(
  parameter int FLUSH_CYCLES = 1,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_exe_valid,
  input  logic [1:0]       i_br_type,
  input  logic             i_br_taken,
  input  logic [31:0]      i_br_target,
  input  logic             i_freeze,
  input  logic             i_clr_stats,
  output logic             o_pc_sel,
  output logic [31:0]      o_pc_target,
  output logic             o_flush_if_id,
  output logic             o_flush_id_exe,
  output logic             o_busy,
  output logic [CNT_W-1:0] o_br_count,
  output logic [CNT_W-1:0] o_taken_count,
  output logic [1:0]       o_state
);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_HOLD     = 2'd1,
    S_REDIRECT = 2'd2,
    S_FLUSH    = 2'd3
  } state_t;

  localparam logic [3:0]       FLUSH_INIT = 4'(FLUSH_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX    = '1;

  state_t           r_state;
  logic [3:0]       r_cnt;
  logic [31:0]      r_pc_target;
  logic [CNT_W-1:0] r_br_count;
  logic [CNT_W-1:0] r_taken_count;

  logic w_take;
  logic w_idle;
  logic w_br_inc;
  logic w_taken_inc;

  // JUMP is taken unconditionally; BEZ/BNE follow the condition check.
  assign w_take      = i_exe_valid & ((i_br_type == 2'b11) | ((i_br_type != 2'b00) & i_br_taken));
  assign w_idle      = (r_state == S_IDLE);
  // A frozen resolution is counted only when it is accepted into HOLD.
  assign w_br_inc    = w_idle & i_exe_valid & (i_br_type != 2'b00) & (~i_freeze | w_take);
  assign w_taken_inc = w_idle & w_take;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_cnt       <= 4'd0;
      r_pc_target <= 32'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_take) begin
            r_pc_target <= i_br_target;
            r_state     <= i_freeze ? S_HOLD : S_REDIRECT;
          end
        end
        S_HOLD: begin
          if (!i_freeze) r_state <= S_REDIRECT;
        end
        S_REDIRECT: begin
          if (!i_freeze) begin
            if (FLUSH_CYCLES == 0) begin
              r_state <= S_IDLE;
            end else begin
              r_state <= S_FLUSH;
              r_cnt   <= FLUSH_INIT;
            end
          end
        end
        S_FLUSH: begin
          if (!i_freeze) begin
            r_cnt <= r_cnt - 4'd1;
            if (r_cnt <= 4'd1) r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Statistics saturate; a clear beats a same-cycle increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_br_count    <= '0;
      r_taken_count <= '0;
    end else if (i_clr_stats) begin
      r_br_count    <= '0;
      r_taken_count <= '0;
    end else begin
      if (w_br_inc && (r_br_count != CNT_MAX))       r_br_count    <= r_br_count + 1'b1;
      if (w_taken_inc && (r_taken_count != CNT_MAX)) r_taken_count <= r_taken_count + 1'b1;
    end
  end

  assign o_pc_sel       = (r_state == S_REDIRECT);
  assign o_flush_id_exe = (r_state == S_REDIRECT);
  assign o_flush_if_id  = (r_state == S_REDIRECT) | (r_state == S_FLUSH);
  assign o_busy         = (r_state != S_IDLE);
  assign o_pc_target    = r_pc_target;
  assign o_br_count     = r_br_count;
  assign o_taken_count  = r_taken_count;
  assign o_state        = r_state;

endmodule

// File: tb/tb_branch_redirect_ctrl.sv
// Bench for branch_redirect_ctrl: two configurations share stimulus; a phase-schedule
// reference model predicts outputs, a negedge monitor pops and compares them.
module tb_branch_redirect_ctrl;

  localparam int W = 68;
  localparam byte PH_H = 8'd1;
  localparam byte PH_R = 8'd2;
  localparam byte PH_F = 8'd3;

  logic        clk;
  logic        rst_n;
  logic        exe_valid;
  logic [1:0]  br_type;
  logic        br_taken;
  logic [31:0] br_target;
  logic        freeze;
  logic        clr_stats;

  logic        a_pc_sel, a_fi, a_fe, a_busy;
  logic [31:0] a_tgt;
  logic [15:0] a_brc, a_tkc;
  logic [1:0]  a_state;
  logic        b_pc_sel, b_fi, b_fe, b_busy;
  logic [31:0] b_tgt;
  logic [3:0]  b_brc, b_tkc;
  logic [1:0]  b_state;

  branch_redirect_ctrl #(.FLUSH_CYCLES(1), .CNT_W(16)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .i_exe_valid(exe_valid), .i_br_type(br_type),
    .i_br_taken(br_taken), .i_br_target(br_target), .i_freeze(freeze), .i_clr_stats(clr_stats),
    .o_pc_sel(a_pc_sel), .o_pc_target(a_tgt), .o_flush_if_id(a_fi), .o_flush_id_exe(a_fe),
    .o_busy(a_busy), .o_br_count(a_brc), .o_taken_count(a_tkc), .o_state(a_state)
  );

  branch_redirect_ctrl #(.FLUSH_CYCLES(3), .CNT_W(4)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .i_exe_valid(exe_valid), .i_br_type(br_type),
    .i_br_taken(br_taken), .i_br_target(br_target), .i_freeze(freeze), .i_clr_stats(clr_stats),
    .o_pc_sel(b_pc_sel), .o_pc_target(b_tgt), .o_flush_if_id(b_fi), .o_flush_id_exe(b_fe),
    .o_busy(b_busy), .o_br_count(b_brc), .o_taken_count(b_tkc), .o_state(b_state)
  );

  // clock/reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  // reference model: a queue of pending phases per configuration
  logic [W-1:0] exp_a[$];
  logic [W-1:0] exp_b[$];
  byte          sq0[$];
  byte          sq1[$];
  logic [31:0]  m_tgt[2];
  int           m_br[2];
  int           m_tk[2];
  int           m_flush[2] = '{1, 3};
  int           m_max[2]   = '{65535, 15};
  int           checks   = 0;
  int           failures = 0;

  function automatic logic [W-1:0] model_out(input int i);
    int  n;
    byte h;
    n = (i == 0) ? sq0.size() : sq1.size();
    h = 8'd0;
    if (n != 0) h = (i == 0) ? sq0[0] : sq1[0];
    return {h == PH_R, m_tgt[i], (h == PH_R) || (h == PH_F), h == PH_R, n != 0,
            16'(m_br[i]), 16'(m_tk[i])};
  endfunction

  task automatic model_reset();
    sq0.delete();
    sq1.delete();
    for (int i = 0; i < 2; i++) begin
      m_tgt[i] = 32'd0;
      m_br[i]  = 0;
      m_tk[i]  = 0;
    end
  endtask

  task automatic sq_push(input int i, input byte p);
    if (i == 0) sq0.push_back(p);
    else        sq1.push_back(p);
  endtask

  task automatic model_step(input int i, input bit v, input bit [1:0] t, input bit tk,
                            input logic [31:0] tgt, input bit frz, input bit clr);
    bit take;
    int n;
    byte d;
    take = v && (t == 2'b11 || (t != 2'b00 && tk));
    n = (i == 0) ? sq0.size() : sq1.size();
    if (n == 0) begin
      if (v && t != 2'b00 && (!frz || take) && m_br[i] < m_max[i]) m_br[i]++;
      if (take) begin
        if (m_tk[i] < m_max[i]) m_tk[i]++;
        m_tgt[i] = tgt;
        if (frz) sq_push(i, PH_H);
        sq_push(i, PH_R);
        for (int k = 0; k < m_flush[i]; k++) sq_push(i, PH_F);
      end
    end else if (!frz) begin
      if (i == 0) d = sq0.pop_front();
      else        d = sq1.pop_front();
    end
    if (clr) begin
      m_br[i] = 0;
      m_tk[i] = 0;
    end
  endtask

  // driver tasks
  task automatic cycle(input bit v, input bit [1:0] t, input bit tk, input logic [31:0] tgt,
                       input bit frz, input bit clr);
    @(posedge clk);
    #1;
    exp_a.push_back(model_out(0));
    exp_b.push_back(model_out(1));
    rst_n     = 1'b1;
    exe_valid = v;
    br_type   = t;
    br_taken  = tk;
    br_target = tgt;
    freeze    = frz;
    clr_stats = clr;
    model_step(0, v, t, tk, tgt, frz, clr);
    model_step(1, v, t, tk, tgt, frz, clr);
  endtask

  task automatic rst_cycle();
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    model_reset();
    exp_a.push_back(model_out(0));
    exp_b.push_back(model_out(1));
    exe_valid = 1'($urandom_range(0, 1));
    br_type   = 2'($urandom_range(0, 3));
    br_taken  = 1'($urandom_range(0, 1));
    br_target = $urandom;
    freeze    = 1'($urandom_range(0, 1));
    clr_stats = 1'($urandom_range(0, 1));
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cycle(0, 2'b00, 0, 32'd0, 0, 0);
  endtask

  // scoreboard / monitor
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h at %0t", name, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    logic [W-1:0] e;
    if (exp_a.size() > 0) begin
      e = exp_a.pop_front();
      chk("A.pc_sel",       32'(a_pc_sel), 32'(e[67]));
      chk("A.pc_target",    a_tgt,         e[66:35]);
      chk("A.flush_if_id",  32'(a_fi),     32'(e[34]));
      chk("A.flush_id_exe", 32'(a_fe),     32'(e[33]));
      chk("A.busy",         32'(a_busy),   32'(e[32]));
      chk("A.br_count",     32'(a_brc),    32'(e[31:16]));
      chk("A.taken_count",  32'(a_tkc),    32'(e[15:0]));
    end
    if (exp_b.size() > 0) begin
      e = exp_b.pop_front();
      chk("B.pc_sel",       32'(b_pc_sel), 32'(e[67]));
      chk("B.pc_target",    b_tgt,         e[66:35]);
      chk("B.flush_if_id",  32'(b_fi),     32'(e[34]));
      chk("B.flush_id_exe", 32'(b_fe),     32'(e[33]));
      chk("B.busy",         32'(b_busy),   32'(e[32]));
      chk("B.br_count",     32'(b_brc),    32'(e[31:16]));
      chk("B.taken_count",  32'(b_tkc),    32'(e[15:0]));
    end
  end

  initial begin
    rst_n = 1'b0; exe_valid = 1'b0; br_type = 2'b00; br_taken = 1'b0;
    br_target = 32'd0; freeze = 1'b0; clr_stats = 1'b0;
    model_reset();

    // reset with random inputs, then release
    for (int k = 0; k < 4; k++) rst_cycle();
    idle(2);

    // BNE taken to 0x40
    cycle(1, 2'b10, 1, 32'h40, 0, 0);
    idle(6);

    // JUMP ignores br_taken; untaken BEZ only counts
    cycle(1, 2'b11, 0, 32'h100, 0, 0);
    idle(6);
    cycle(1, 2'b01, 0, 32'h180, 0, 0);
    idle(2);

    // taken under freeze -> HOLD, then REDIRECT held by freeze
    cycle(1, 2'b10, 1, 32'h60, 1, 0);
    cycle(1, 2'b11, 1, 32'h99, 1, 0);
    cycle(1, 2'b01, 1, 32'h9c, 1, 0);
    cycle(0, 2'b00, 0, 32'd0, 0, 0);
    cycle(0, 2'b00, 0, 32'd0, 1, 0);
    cycle(0, 2'b00, 0, 32'd0, 1, 0);
    idle(6);

    // second take during FLUSH is wrong-path
    cycle(1, 2'b10, 1, 32'h40, 0, 0);
    cycle(0, 2'b00, 0, 32'd0, 0, 0);
    cycle(1, 2'b11, 1, 32'h80, 0, 0);
    idle(6);

    // saturation, then clear racing a take
    for (int k = 0; k < 16; k++) begin
      cycle(1, 2'b11, 0, 32'h200 + 32'(k * 4), 0, 0);
      idle(5);
    end
    cycle(1, 2'b10, 1, 32'h300, 0, 1);
    idle(6);

    // asynchronous reset in the middle of a held REDIRECT
    cycle(1, 2'b01, 1, 32'h500, 0, 0);
    cycle(0, 2'b00, 0, 32'd0, 1, 0);
    rst_cycle();
    rst_cycle();
    idle(3);

    // randomized traffic
    for (int k = 0; k < 600; k++) begin
      cycle(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
            $urandom, $urandom_range(0, 3) == 0, $urandom_range(0, 31) == 0);
    end
    idle(2);

    @(negedge clk);
    #1;
    checks++;
    if (exp_a.size() != 0 || exp_b.size() != 0) begin
      failures++;
      $display("FAIL drain got=%0d expected=0", exp_a.size() + exp_b.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
